// File: rtl/uart_rx_8n1_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM state encoding and frame constants.
package uart_rx_8n1_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } rx_state_e;

    localparam int unsigned DataBits = 8;
    localparam logic        LineIdle = 1'b1;

endpackage

// File: rtl/uart_rx_8n1_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, resetting to ResetVal.
module uart_rx_8n1_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {ResetVal, ResetVal};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its centre, strobes good bytes
// and flags frames whose stop bit is low.
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rx_i,
    output logic [DataBits-1:0] rxbyte_o,
    output logic                rxvalid_o,
    output logic                framing_err_o,
    output logic                busy_o
);

    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LastBit  = 3'(DataBits - 1);

    logic                rx_s;
    rx_state_e           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2:0]          bitidx_q, bitidx_d;
    logic [DataBits-1:0] shreg_q, shreg_d;
    logic [DataBits-1:0] rxbyte_q, rxbyte_d;
    logic                rxvalid_q, rxvalid_d;
    logic                ferr_q, ferr_d;

    uart_rx_8n1_sync2 #(
        .ResetVal(LineIdle)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bitidx_q  <= '0;
            shreg_q   <= '0;
            rxbyte_q  <= '0;
            rxvalid_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitidx_q  <= bitidx_d;
            shreg_q   <= shreg_d;
            rxbyte_q  <= rxbyte_d;
            rxvalid_q <= rxvalid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitidx_d  = bitidx_q;
        shreg_d   = shreg_q;
        rxbyte_d  = rxbyte_q;
        rxvalid_d = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rx_s != LineIdle) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d    = '0;
                    bitidx_d = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d  = (rx_s == LineIdle) ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d    = '0;
                    shreg_d  = {rx_s, shreg_q[DataBits-1:1]};
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == LastBit) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s == LineIdle) begin
                        rxbyte_d  = shreg_q;
                        rxvalid_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBreak: begin
                // Only a return to idle re-arms start detection after a low stop bit.
                cnt_d = '0;
                if (rx_s == LineIdle) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign rxbyte_o      = rxbyte_q;
    assign rxvalid_o     = rxvalid_q;
    assign framing_err_o = ferr_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: drives 8N1 frames from a timed line model and
// compares received bytes, strobe timing and error pulses against expectations.
module tb_uart_rx_8n1;

    localparam int unsigned N     = 16;
    localparam int unsigned ClkNs = 10;
    localparam int unsigned BitNs = N * ClkNs;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rxbyte;
    logic       rxvalid;
    logic       ferr;
    logic       busy;

    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ferr_cnt = 0;
    int unsigned t0;
    logic [7:0]  got_q[$];
    int unsigned at_q[$];
    logic [7:0]  exp_q[$];

    uart_rx_8n1 #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx),
        .rxbyte_o     (rxbyte),
        .rxvalid_o    (rxvalid),
        .framing_err_o(ferr),
        .busy_o       (busy)
    );

    always #(ClkNs / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Strobes are observed mid-cycle; cyc then names the edge that raised them.
    always @(negedge clk) begin
        if (rxvalid) begin
            got_q.push_back(rxbyte);
            at_q.push_back(cyc);
        end
        if (ferr) ferr_cnt++;
        if (rxvalid || ferr) check("valid_ferr_exclusive", {31'd0, rxvalid & ferr}, 32'd0);
    end

    // Line model: start, 8 data bits LSB first, stop; bit period in ns.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int unsigned bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_q.delete();
        at_q.delete();
        ferr_cnt = 0;
    endtask

    initial begin
        wait_cycles(3);
        check("reset_rxbyte", {24'd0, rxbyte}, 32'h00);
        check("reset_rxvalid", {31'd0, rxvalid}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(4);

        // Single frame and strobe latency
        clear_obs();
        @(negedge clk);
        t0 = cyc;
        drive_frame(8'hA5, 1'b1, BitNs);
        wait_cycles(20);
        check("t1_count", got_q.size(), 32'd1);
        if (got_q.size() == 1) begin
            check("t1_byte", {24'd0, got_q[0]}, 32'hA5);
            check("t1_latency", at_q[0], t0 + 1 + 2 + N / 2 + 9 * N);
        end
        check("t1_ferr", ferr_cnt, 32'd0);

        // Back-to-back frames, no idle gap
        clear_obs();
        @(negedge clk);
        t0 = cyc;
        drive_frame(8'h00, 1'b1, BitNs);
        drive_frame(8'hFF, 1'b1, BitNs);
        drive_frame(8'h55, 1'b1, BitNs);
        wait_cycles(20);
        check("t2_count", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            check("t2_byte0", {24'd0, got_q[0]}, 32'h00);
            check("t2_byte1", {24'd0, got_q[1]}, 32'hFF);
            check("t2_byte2", {24'd0, got_q[2]}, 32'h55);
            check("t2_first_at", at_q[0], t0 + 1 + 2 + N / 2 + 9 * N);
            check("t2_gap01", at_q[1] - at_q[0], 10 * N);
            check("t2_gap12", at_q[2] - at_q[1], 10 * N);
        end
        check("t2_ferr", ferr_cnt, 32'd0);

        // Short low glitch is rejected at the mid-start check
        clear_obs();
        @(negedge clk);
        t0 = cyc;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        check("t3_busy_during", {31'd0, busy}, 32'd1);
        wait_cycles(N / 2 + 3 - 4);
        check("t3_busy_cleared", {31'd0, busy}, 32'd0);
        wait_cycles(12 * N);
        check("t3_no_valid", got_q.size(), 32'd0);
        check("t3_no_ferr", ferr_cnt, 32'd0);

        // Low stop bit, held break, then a good frame
        clear_obs();
        @(negedge clk);
        drive_frame(8'h3C, 1'b0, BitNs);
        wait_cycles(3 * N);
        check("t4_busy_in_break", {31'd0, busy}, 32'd1);
        check("t4_ferr_once", ferr_cnt, 32'd1);
        check("t4_no_valid", got_q.size(), 32'd0);
        check("t4_rxbyte_held", {24'd0, rxbyte}, 32'h55);
        rx = 1'b1;
        wait_cycles(N);
        check("t4_idle_after_break", {31'd0, busy}, 32'd0);
        drive_frame(8'h81, 1'b1, BitNs);
        wait_cycles(20);
        check("t4_count", got_q.size(), 32'd1);
        if (got_q.size() == 1) check("t4_byte", {24'd0, got_q[0]}, 32'h81);
        check("t4_ferr_total", ferr_cnt, 32'd1);

        // Reset asserted in the middle of data bit 4, held until the frame has passed
        clear_obs();
        @(negedge clk);
        fork
            drive_frame(8'hC3, 1'b1, BitNs);
            begin
                #(BitNs * 5 + BitNs / 2);
                rst_n = 1'b0;
                #1;
                check("t5_rst_rxbyte", {24'd0, rxbyte}, 32'h00);
                check("t5_rst_rxvalid", {31'd0, rxvalid}, 32'd0);
                check("t5_rst_ferr", {31'd0, ferr}, 32'd0);
                check("t5_rst_busy", {31'd0, busy}, 32'd0);
            end
        join
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(N);
        check("t5_no_strobe", got_q.size() + ferr_cnt, 32'd0);
        drive_frame(8'h7E, 1'b1, BitNs);
        wait_cycles(20);
        check("t5_count", got_q.size(), 32'd1);
        if (got_q.size() == 1) check("t5_byte", {24'd0, got_q[0]}, 32'h7E);

        // All byte values with randomized bit period (+/-3%) and random idle gaps.
        // A whole clk per bit (6%) is beyond what mid-bit sampling tolerates over 10 bits.
        clear_obs();
        exp_q.delete();
        for (int b = 0; b < 256; b++) begin
            exp_q.push_back(8'(b));
            drive_frame(8'(b), 1'b1, $urandom_range(BitNs + 5, BitNs - 5));
            rx = 1'b1;
            #($urandom_range(30, 0));
        end
        wait_cycles(2 * N);
        check("t6_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("t6_byte_%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        check("t6_ferr", ferr_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
